conv_tap_sequencer: RTL

Control stage directly upstream of the 4-bit tap counter in the convolution datapath. It owns the counter's `enable` input and reads back `counter_out` as the current tap index. For each accepted window request it issues one buffer read per kernel tap and flags the first and last taps to the MAC accumulator. It then pulses `done`. The tap counter is never cleared between windows, so the sequencer works relative to a latched origin and tolerates 4-bit wrap-around.

---
 rtl/conv_tap_sequencer_if.sv | 29 ++
 rtl/conv_tap_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/conv_tap_sequencer_if.sv
// Window request, abort, tap-counter and buffer-read signals between the
// convolution controller side and the tap sequencer.
interface conv_tap_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] base_addr;
  logic              abort;
  logic [3:0]        tap_idx;
  logic              tap_cnt_en;
  logic              rd_en;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              acc_clr;
  logic              acc_last;
  logic              busy;
  logic              done;

  modport master (
    output start_valid, base_addr, abort, tap_idx, rd_ready,
    input  start_ready, tap_cnt_en, rd_en, rd_addr, acc_clr, acc_last, busy, done
  );

  modport slave (
    input  start_valid, base_addr, abort, tap_idx, rd_ready,
    output start_ready, tap_cnt_en, rd_en, rd_addr, acc_clr, acc_last, busy, done
  );
endinterface

// File: rtl/conv_tap_sequencer.sv
// Issues one buffer read per kernel tap relative to a latched tap-counter origin.
// Taps 0..N-1 issue in cycles t+1..t+N after acceptance, done at t+N+1; rd_ready low holds the current tap.
module conv_tap_sequencer #(
  parameter int KERNEL_TAPS = 9,
  parameter int ADDR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_tap_sequencer_if.slave  sif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_OFF = 4'(KERNEL_TAPS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_r, base_d;
  logic [3:0]        origin_r, origin_d;
  logic [3:0]        offset;

  logic              start_ready_c;
  logic              tap_cnt_en_c;
  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              acc_clr_c;
  logic              acc_last_c;
  logic              busy_c;
  logic              done_c;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_r   <= '0;
      origin_r <= '0;
    end else begin
      state_q  <= state_d;
      base_r   <= base_d;
      origin_r <= origin_d;
    end
  end

  // Modular difference keeps the tap position correct across counter wrap.
  assign offset = sif.tap_idx - origin_r;

  always_comb begin
    state_d       = state_q;
    base_d        = base_r;
    origin_d      = origin_r;
    start_ready_c = 1'b0;
    tap_cnt_en_c  = 1'b0;
    rd_en_c       = 1'b0;
    rd_addr_c     = '0;
    acc_clr_c     = 1'b0;
    acc_last_c    = 1'b0;
    busy_c        = 1'b0;
    done_c        = 1'b0;
    xfer          = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready_c = 1'b1;
        if (sif.start_valid) begin
          base_d   = sif.base_addr;
          origin_d = sif.tap_idx;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy_c       = 1'b1;
        rd_en_c      = !sif.abort;
        rd_addr_c    = base_r + ADDR_W'(offset);
        acc_clr_c    = rd_en_c && (offset == 4'd0);
        acc_last_c   = rd_en_c && (offset == LAST_OFF);
        xfer         = rd_en_c && sif.rd_ready;
        tap_cnt_en_c = xfer;
        if (sif.abort) begin
          state_d = IDLE;
        end else if (xfer && acc_last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every output low, including the request handshake.
  assign sif.start_ready = start_ready_c & !rst;
  assign sif.tap_cnt_en  = tap_cnt_en_c & !rst;
  assign sif.rd_en       = rd_en_c & !rst;
  assign sif.rd_addr     = rst ? '0 : rd_addr_c;
  assign sif.acc_clr     = acc_clr_c & !rst;
  assign sif.acc_last    = acc_last_c & !rst;
  assign sif.busy        = busy_c & !rst;
  assign sif.done        = done_c & !rst;

endmodule
